// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: mantissa/product widths, the
// iterative multiplier state encoding and the mantissa/product types.
package fpu_pkg;

  localparam int MANT_LENGTH = 24;
  localparam int PROD_LENGTH = 2 * MANT_LENGTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef logic [MANT_LENGTH-1:0] mant_t;
  typedef logic [PROD_LENGTH-1:0] prod_t;

endpackage : fpu_pkg

// File: rtl/seq_mantissa_multiplier_if.sv
// Operand/result handshake bundle for seq_mantissa_multiplier; the master
// supplies operands and consumes the product, the slave is the multiplier.
interface seq_mantissa_multiplier_if #(
  parameter int MULTIPLICAND_LENGTH = fpu_pkg::MANT_LENGTH,
  parameter int MULTIPLIER_LENGTH   = fpu_pkg::MANT_LENGTH
);
  localparam int PRODUCT_LENGTH = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH;

  logic                           in_valid;
  logic                           in_ready;
  logic [MULTIPLICAND_LENGTH-1:0] multiplicand;
  logic [MULTIPLIER_LENGTH-1:0]   multiplier;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [PRODUCT_LENGTH-1:0]      product;
  logic                           ge;

  modport master (
    output in_valid, multiplicand, multiplier, flush, out_ready,
    input  in_ready, out_valid, product, ge
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, flush, out_ready,
    output in_ready, out_valid, product, ge
  );

endinterface : seq_mantissa_multiplier_if

// File: rtl/mul_step_adder.sv
// One combinational shift-add step of the iterative multiplier. Radix-2 by
// default; MUL_RADIX4_EN retires two multiplier bits per step.
module mul_step_adder #(
  parameter int A_WIDTH = 24,
  parameter int B_WIDTH = 24
) (
  input  logic [A_WIDTH-1:0] a,
`ifdef MUL_RADIX4_EN
  input  logic [A_WIDTH+1:0] a3,
`endif
  input  logic [A_WIDTH-1:0] hi,
  input  logic [B_WIDTH-1:0] lo,
  output logic [A_WIDTH-1:0] hi_next,
  output logic [B_WIDTH-1:0] lo_next
);

`ifdef MUL_RADIX4_EN
  logic [A_WIDTH+1:0] multiple;
  logic [A_WIDTH+1:0] sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    multiple = '0;
    unique case (lo[1:0])
      2'd0: multiple = '0;
      2'd1: multiple = {2'b00, a};
      2'd2: multiple = {1'b0, a, 1'b0};
      2'd3: multiple = a3;
    endcase
  end

  // hi < 2^A and 3A < 3*2^A, so the sum always fits A_WIDTH+2 bits.
  assign sum     = {2'b00, hi} + multiple;
  assign hi_next = sum[A_WIDTH+1:2];
  assign lo_next = {sum[1:0], lo[B_WIDTH-1:2]};
`else
  logic [A_WIDTH:0] sum;

  // The carry out of the add becomes the new hi MSB after the shift.
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
  assign hi_next = sum[A_WIDTH:1];
  assign lo_next = {sum[0], lo[B_WIDTH-1:1]};
`endif

endmodule : mul_step_adder

// File: rtl/seq_mantissa_multiplier.sv
// Iterative unsigned mantissa multiplier (shift-add) with valid/ready handshake
// and ge flag for the FP_MUL normalizer. Optional feature macro: MUL_RADIX4_EN.
module seq_mantissa_multiplier
  import fpu_pkg::*;
#(
  parameter int MULTIPLICAND_LENGTH = MANT_LENGTH,
  parameter int MULTIPLIER_LENGTH   = MANT_LENGTH
) (
  input logic                     clk,
  input logic                     rst_n,
  seq_mantissa_multiplier_if.slave bus
);

  localparam int PRODUCT_LENGTH = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH;
  localparam int COUNT_W        = $clog2(MULTIPLIER_LENGTH);
`ifdef MUL_RADIX4_EN
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(MULTIPLIER_LENGTH / 2 - 1);
`else
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(MULTIPLIER_LENGTH - 1);
`endif

  mul_state_e                     state_q, state_d;
  logic [MULTIPLICAND_LENGTH-1:0] a_q;
  logic [MULTIPLICAND_LENGTH-1:0] hi_q, hi_next;
  logic [MULTIPLIER_LENGTH-1:0]   lo_q, lo_next;
  logic [COUNT_W-1:0]             count_q;
  logic                           accept;

`ifdef MUL_RADIX4_EN
  logic [MULTIPLICAND_LENGTH+1:0] a3_q;
`endif

  assign accept = (state_q == IDLE) && bus.in_valid && !bus.flush;

  mul_step_adder #(
    .A_WIDTH(MULTIPLICAND_LENGTH),
    .B_WIDTH(MULTIPLIER_LENGTH)
  ) u_step (
    .a       (a_q),
`ifdef MUL_RADIX4_EN
    .a3      (a3_q),
`endif
    .hi      (hi_q),
    .lo      (lo_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)          state_d = BUSY;
      BUSY:    if (count_q == LAST_COUNT) state_d = DONE;
      DONE:    if (bus.out_ready)         state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
    // Flush outranks every transition, including an accept in IDLE.
    if (bus.flush) state_d = IDLE;
  end

  // NOTE: datapath registers are reset because product is driven straight
  // from hi/lo and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
`ifdef MUL_RADIX4_EN
      a3_q    <= '0;
`endif
    end else if (bus.flush) begin
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else if (accept) begin
      a_q     <= bus.multiplicand;
      hi_q    <= '0;
      lo_q    <= bus.multiplier;
      count_q <= '0;
`ifdef MUL_RADIX4_EN
      a3_q    <= {2'b00, bus.multiplicand} + {1'b0, bus.multiplicand, 1'b0};
`endif
    end else if (state_q == BUSY) begin
      hi_q    <= hi_next;
      lo_q    <= lo_next;
      count_q <= count_q + 1'b1;
    end
  end

  // hi/lo only move in BUSY or on accept, so the result holds under backpressure.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = PRODUCT_LENGTH'({hi_q, lo_q});
  assign bus.ge        = hi_q[MULTIPLICAND_LENGTH-1];

endmodule : seq_mantissa_multiplier
